// File: rtl/instruction_utils_pkg.sv
// +--------------------------------------------------------------------------+
// | instruction_utils : shared encodings for the instruction fetch path       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package instruction_utils;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_buffer.sv
// +--------------------------------------------------------------------------+
// | fetch_buffer : small FIFO of fetched {pc, instr} pairs; flush beats push |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_buffer
  import instruction_utils::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  entries [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) entries[wr_ptr] <= push_data;
  end

  assign head = entries[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +--------------------------------------------------------------------------+
// | fetch_stage : PC, instruction-memory request FSM and IF/ID registers     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_stage
  import instruction_utils::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_if_take_branch,
  input  logic [31:0] ex_if_branch_target,
  output logic        imem_read_en,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc
);

  localparam int          CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  fetch_state_e  state, state_next;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  resp;
  logic          redirect, resp_ok, push, pop, bypass, issue;
  logic [CW:0]   occ_next;
  logic          unused_target_bits;

  assign unused_target_bits = ^ex_if_branch_target[1:0];

  assign redirect = ex_if_take_branch;
  assign resp_ok  = (state == S_WAIT) && imem_valid;
  assign push     = resp_ok && !redirect;
  assign pop      = !redirect && !stall && ((count != '0) || push);
  // Empty buffer plus a same-cycle response: skip the FIFO entirely.
  assign bypass   = push && pop && (count == '0);
  assign occ_next = (CW + 1)'(count) + (CW + 1)'(push) - (CW + 1)'(pop);
  assign resp     = '{pc: req_pc, instr: imem_rdata};

  // A new request may only go out when nothing else is in flight or the
  // in-flight one is completing now, keeping a single outstanding request.
  assign issue = !rst && !redirect && (occ_next < DEPTH_W) &&
                 ((state == S_IDLE) || resp_ok);

  assign imem_read_en = issue;
  assign imem_addr    = pc;

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (issue) state_next = S_WAIT;
      S_WAIT: begin
        if (redirect)        state_next = imem_valid ? S_IDLE : S_DISCARD;
        else if (imem_valid) state_next = issue ? S_WAIT : S_IDLE;
      end
      S_DISCARD: if (imem_valid) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      req_pc      <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        pc <= {ex_if_branch_target[31:2], 2'b00};
      end else if (issue) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
      if (redirect) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
        if_id_pc    <= '0;
      end else if (!stall) begin
        if (pop) begin
          if_id_valid <= 1'b1;
          if_id_instr <= bypass ? resp.instr : head.instr;
          if_id_pc    <= bypass ? resp.pc    : head.pc;
        end else begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
      end
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push && !bypass),
    .push_data (resp),
    .pop       (pop && !bypass),
    .head      (head),
    .count     (count)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +--------------------------------------------------------------------------+
// | tb_fetch_stage : directed scenarios plus random traffic vs queue model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        take = 1'b0;
  logic [31:0] target = '0;
  logic        read_en;
  logic [31:0] addr;
  logic        valid = 1'b0;
  logic [31:0] rdata = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .ex_if_take_branch   (take),
    .ex_if_branch_target (target),
    .imem_read_en        (read_en),
    .imem_addr           (addr),
    .imem_valid          (valid),
    .imem_rdata          (rdata),
    .if_id_valid         (id_valid),
    .if_id_instr         (id_instr),
    .if_id_pc            (id_pc)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory environment: one pending request answered after lat cycles.
  int          lat = 1;
  bit          m_pend = 0;
  logic [31:0] m_addr;
  int          m_rem;
  bit          stale_inj = 0;

  // Reference model: fetch queue, one outstanding request, IF/ID contents.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  bit          o_out = 0, o_sq = 0;
  logic [31:0] o_addr;
  logic [31:0] next_pc = RPC;
  bit          e_valid = 0;
  logic [31:0] e_pc = 0, e_instr = NOP;

  bit          obs_req;
  logic [31:0] obs_addr;
  bit          obs_ifv;
  logic [31:0] obs_ifpc, obs_ifinstr;

  task automatic model_reset();
    q.delete();
    o_out = 0; o_sq = 0;
    next_pc = RPC;
    e_valid = 0; e_pc = 0; e_instr = NOP;
  endtask

  task automatic model_cycle(input bit st, input bit rd, input logic [31:0] tg);
    bit   exp_req;
    bit   dropped;
    ent_t e;
    exp_req = 0;
    dropped = 0;
    check("if_id_valid", id_valid, e_valid);
    check("if_id_pc", id_pc, e_pc);
    check("if_id_instr", id_instr, e_instr);
    if (rd) begin
      check("imem_read_en", read_en, 0);
      e_valid = 0; e_pc = 0; e_instr = NOP;
      q.delete();
      next_pc = tg & 32'hFFFF_FFFC;
      if (o_out) begin
        if (valid) o_out = 0;
        else       o_sq  = 1;
      end
    end else begin
      if (o_out && valid) begin
        if (o_sq) dropped = 1;
        else      q.push_back('{pc: o_addr, instr: rdata});
        o_out = 0;
        o_sq  = 0;
      end
      if (!st) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          e_valid = 1; e_pc = e.pc; e_instr = e.instr;
        end else begin
          e_valid = 0; e_instr = NOP;
        end
      end
      exp_req = !dropped && !o_out && (q.size() < DEPTH);
      check("imem_read_en", read_en, exp_req);
      if (exp_req) begin
        check("imem_addr", addr, next_pc);
        o_out = 1; o_sq = 0; o_addr = next_pc;
        next_pc = next_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] tg);
    @(negedge clk);
    rst = r; stall = st; take = rd; target = tg;
    valid = 0; rdata = $urandom;
    if (r) begin
      m_pend = 0;
    end else if (stale_inj) begin
      valid = 1; rdata = 32'hDEAD_BEEF; stale_inj = 0;
    end else if (m_pend) begin
      if (m_rem == 0) begin
        valid = 1; rdata = {m_addr[15:0], 16'hA5A5}; m_pend = 0;
      end else begin
        m_rem--;
      end
    end
    #1;
    obs_req = read_en; obs_addr = addr;
    obs_ifv = id_valid; obs_ifpc = id_pc; obs_ifinstr = id_instr;
    if (r) begin
      model_reset();
      check("reset imem_read_en", read_en, 0);
      check("reset if_id_valid", id_valid, 0);
      check("reset if_id_instr", id_instr, NOP);
      check("reset if_id_pc", id_pc, 0);
    end else begin
      model_cycle(st, rd, tg);
      if (read_en) begin
        m_pend = 1; m_addr = addr; m_rem = lat - 1;
      end
    end
  endtask

  task automatic reset_seq(input bit stale);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    stale_inj = stale;
  endtask

  initial begin
    bit          seen_req, seen_valid;
    int          early_valid;
    // T1/T2: 1-cycle memory, streaming fetch
    lat = 1;
    reset_seq(0);
    step(0, 0, 0, 0);
    check("T1 c1 read_en", obs_req, 1);
    check("T1 c1 addr", obs_addr, 32'h0);
    step(0, 0, 0, 0);
    check("T1 c2 addr", obs_addr, 32'h4);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      check("T2 if_id_valid", obs_ifv, 1);
      check("T2 if_id_pc", obs_ifpc, 32'(4 * k));
      if (k == 0) check("T1 first instr", obs_ifinstr, 32'h0000_A5A5);
    end
    // T3: stall freezes IF/ID and fills the buffer
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0);
      check("T3 frozen pc", obs_ifpc, 32'h10);
      if (k >= 2) check("T3 read_en low", obs_req, 0);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      check("T3 resume pc", obs_ifpc, 32'(32'h10 + 4 * k));
    end
    // T5: redirect together with stall while buffer holds two
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("T5 full read_en", obs_req, 0);
    step(0, 1, 1, 32'h200);
    step(0, 0, 0, 0);
    check("T5 if_id_valid", obs_ifv, 0);
    check("T5 read_en", obs_req, 1);
    check("T5 addr", obs_addr, 32'h200);

    // T4: redirect while 0x8 outstanding with 3-cycle memory
    lat = 3;
    reset_seq(0);
    seen_req = 0;
    for (int k = 0; k < 20 && !seen_req; k++) begin
      step(0, 0, 0, 0);
      seen_req = obs_req && (obs_addr == 32'h8);
    end
    check("T4 reached 0x8 request", seen_req, 1);
    step(0, 0, 1, 32'h103);
    seen_req = 0; seen_valid = 0; early_valid = 0;
    for (int k = 0; k < 20 && !seen_valid; k++) begin
      step(0, 0, 0, 0);
      if (obs_req && !seen_req) begin
        seen_req = 1;
        check("T4 first addr after redirect", obs_addr, 32'h100);
      end
      if (obs_ifv) begin
        seen_valid = 1;
        check("T4 first pc after redirect", obs_ifpc, 32'h100);
        check("T4 first instr after redirect", obs_ifinstr, 32'h0100_A5A5);
      end
    end
    check("T4 instruction arrived", seen_valid, 1);

    // T6: reset mid-request, stale response after release
    lat = 3;
    reset_seq(0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset_seq(1);
    seen_valid = 0;
    for (int k = 0; k < 20 && !seen_valid; k++) begin
      step(0, 0, 0, 0);
      if (obs_ifv) begin
        seen_valid = 1;
        check("T6 first pc", obs_ifpc, RPC);
        check("T6 first instr", obs_ifinstr, {RPC[15:0], 16'hA5A5});
      end
    end
    check("T6 instruction arrived", seen_valid, 1);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        lat = $urandom_range(1, 4);
        reset_seq(1'($urandom_range(0, 1)));
      end
      step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
